// File: rtl/load_store_unit.sv
// Load/store bridge between the core execute stage and a word-wide data_mem.
// Byte/half loads are lane-extracted and extended; SB/SH become read-modify-write.
module load_store_unit #(
    parameter bit MISALIGN_TRAP = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        misalign_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        RMW_WAIT  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [XLEN-1:0]   r_addr;
    logic [2:0]        r_size;
    logic [15:0]       r_wd;
    logic [XLEN-1:0]   r_rd;

    logic              w_is_byte;
    logic              w_is_half;
    logic              w_misaligned;
    logic              w_trap;
    logic              w_accept;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [XLEN-1:0]   w_load;
    logic [XLEN-1:0]   w_merge;

    assign w_is_byte    = (core_size_i[1:0] == 2'b00);
    assign w_is_half    = (core_size_i[1:0] == 2'b01);
    assign w_misaligned = (w_is_half && core_addr_i[0]) ||
                          (!w_is_byte && !w_is_half && (core_addr_i[1:0] != 2'b00));
    assign w_trap       = MISALIGN_TRAP && w_misaligned;
    assign w_accept     = (r_state == IDLE) && core_req_i && !w_trap;

    // Lane select and sign/zero extension of the returned read word.
    always_comb begin
        w_byte = mem_rd_i[{r_addr[1:0], 3'b000} +: 8];
        w_half = r_addr[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
        case (r_size[1:0])
            2'b00:   w_load = r_size[2] ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load = r_size[2] ? {16'h0000, w_half}   : {{16{w_half[15]}}, w_half};
            default: w_load = mem_rd_i;
        endcase
    end

    // Sub-word store merge into the word read during the RMW.
    always_comb begin
        w_merge = mem_rd_i;
        if (r_size[1:0] == 2'b00) begin
            w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wd[7:0];
        end else begin
            w_merge[{r_addr[1], 4'b0000} +: 16] = r_wd;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_size  <= '0;
            r_wd    <= '0;
            r_rd    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr <= core_addr_i;
                r_size <= core_size_i;
                r_wd   <= core_wd_i[15:0];
            end
            if (r_state == LOAD_WAIT) begin
                r_rd <= w_load;
            end
        end
    end

    // Next state and memory/core handshake; everything is forced low while reset is held.
    always_comb begin
        w_state_nxt  = r_state;
        core_rd_o    = r_rd;
        core_stall_o = 1'b0;
        misalign_o   = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wd_o     = '0;
        case (r_state)
            IDLE: begin
                if (core_req_i) begin
                    if (w_trap) begin
                        misalign_o = 1'b1;
                    end else begin
                        mem_req_o  = 1'b1;
                        mem_addr_o = {core_addr_i[31:2], 2'b00};
                        if (!core_we_i) begin
                            core_stall_o = 1'b1;
                            w_state_nxt  = LOAD_WAIT;
                        end else if (!w_is_byte && !w_is_half) begin
                            mem_we_o = 1'b1;
                            mem_wd_o = core_wd_i;
                        end else begin
                            core_stall_o = 1'b1;
                            w_state_nxt  = RMW_WAIT;
                        end
                    end
                end
            end
            LOAD_WAIT: begin
                core_rd_o   = w_load;
                w_state_nxt = IDLE;
            end
            RMW_WAIT: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {r_addr[31:2], 2'b00};
                mem_wd_o    = w_merge;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (!rst_i) begin
            core_rd_o    = '0;
            core_stall_o = 1'b0;
            misalign_o   = 1'b0;
            mem_req_o    = 1'b0;
            mem_we_o     = 1'b0;
            mem_addr_o   = '0;
            mem_wd_o     = '0;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural data_mem, vector table with a scoreboard
// queue, plus hand sequences for back-to-back requests and reset during RMW.
module tb_load_store_unit;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        misalign_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;

    load_store_unit #(.MISALIGN_TRAP(1'b1)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .core_req_i  (core_req_i),
        .core_we_i   (core_we_i),
        .core_size_i (core_size_i),
        .core_addr_i (core_addr_i),
        .core_wd_i   (core_wd_i),
        .core_rd_o   (core_rd_o),
        .core_stall_o(core_stall_o),
        .misalign_o  (misalign_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wd_o    (mem_wd_o),
        .mem_rd_i    (mem_rd_i)
    );

    always #5 clk_i = ~clk_i;

    // data_mem model: 256 words, 1-cycle sync read, out-of-range reads return DEADBEEF.
    logic [31:0] mem [0:255];
    logic        mem_init;
    always @(posedge clk_i) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[4]   <= 32'h8899AABB;
            mem_rd_i <= 32'h0;
        end else if (mem_req_o) begin
            if (mem_we_o) begin
                if (mem_addr_o[31:10] == 22'h0) mem[mem_addr_o[9:2]] <= mem_wd_o;
            end else begin
                mem_rd_i <= (mem_addr_o[31:10] == 22'h0) ? mem[mem_addr_o[9:2]] : 32'hDEADBEEF;
            end
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        chk_rd;
        logic [31:0] exp_rd;
        int          exp_stall;
        logic        exp_mis;
        logic        exp_wr;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t sb_q[$];
    vec_t tbl[21];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] size, input logic [31:0] addr,
                                input logic [31:0] wd, input logic chk_rd, input logic [31:0] exp_rd,
                                input int stall, input logic mis, input logic wr, input logic [31:0] exp_wd);
        vec_t v;
        v.we = we; v.size = size; v.addr = addr; v.wd = wd;
        v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_stall = stall;
        v.exp_mis = mis; v.exp_wr = wr; v.exp_wd = exp_wd;
        return v;
    endfunction

    // Drive one op, observe it to completion, then pop its expectation and compare.
    task automatic run_op(input int idx, input vec_t v);
        vec_t        e;
        int          stalls;
        logic        mis, wr, req0;
        logic [31:0] wd, rd, addr0;
        @(negedge clk_i);
        core_req_i  = 1'b1;
        core_we_i   = v.we;
        core_size_i = v.size;
        core_addr_i = v.addr;
        core_wd_i   = v.wd;
        sb_q.push_back(v);
        #1;
        stalls = 0;
        mis    = misalign_o;
        req0   = mem_req_o;
        addr0  = mem_addr_o;
        wr     = mem_req_o && mem_we_o;
        wd     = wr ? mem_wd_o : 32'h0;
        while (core_stall_o && stalls < 8) begin
            @(posedge clk_i); #1;
            stalls++;
            if (mem_req_o && mem_we_o) begin
                wr = 1'b1;
                wd = mem_wd_o;
            end
        end
        rd = core_rd_o;
        @(posedge clk_i); #1;
        core_req_i = 1'b0;
        e = sb_q.pop_front();
        check($sformatf("v%0d stall_cycles", idx), 32'(stalls), 32'(e.exp_stall));
        check($sformatf("v%0d misalign", idx), 32'(mis), 32'(e.exp_mis));
        check($sformatf("v%0d write_issued", idx), 32'(wr), 32'(e.exp_wr));
        if (e.exp_wr) check($sformatf("v%0d write_data", idx), wd, e.exp_wd);
        if (e.chk_rd) check($sformatf("v%0d load_data", idx), rd, e.exp_rd);
        if (e.exp_mis) check($sformatf("v%0d req_suppressed", idx), 32'(req0), 32'h0);
        else check($sformatf("v%0d mem_addr", idx), addr0, {e.addr[31:2], 2'b00});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = mk(0, SZ_W,  32'h10,   32'h0,        1, 32'h8899AABB, 1, 0, 0, 32'h0);
        tbl[1]  = mk(0, SZ_B,  32'h13,   32'h0,        1, 32'hFFFFFF88, 1, 0, 0, 32'h0);
        tbl[2]  = mk(0, SZ_BU, 32'h13,   32'h0,        1, 32'h00000088, 1, 0, 0, 32'h0);
        tbl[3]  = mk(0, SZ_H,  32'h12,   32'h0,        1, 32'hFFFF8899, 1, 0, 0, 32'h0);
        tbl[4]  = mk(0, SZ_HU, 32'h10,   32'h0,        1, 32'h0000AABB, 1, 0, 0, 32'h0);
        tbl[5]  = mk(0, SZ_B,  32'h10,   32'h0,        1, 32'hFFFFFFBB, 1, 0, 0, 32'h0);
        tbl[6]  = mk(0, SZ_BU, 32'h11,   32'h0,        1, 32'h000000AA, 1, 0, 0, 32'h0);
        tbl[7]  = mk(1, SZ_B,  32'h11,   32'h123,      0, 32'h0,        1, 0, 1, 32'h889923BB);
        tbl[8]  = mk(0, SZ_W,  32'h10,   32'h0,        1, 32'h889923BB, 1, 0, 0, 32'h0);
        tbl[9]  = mk(1, SZ_W,  32'h20,   32'hCAFEF00D, 0, 32'h0,        0, 0, 1, 32'hCAFEF00D);
        tbl[10] = mk(1, SZ_H,  32'h22,   32'hBEEF,     0, 32'h0,        1, 0, 1, 32'hBEEFF00D);
        tbl[11] = mk(0, SZ_W,  32'h20,   32'h0,        1, 32'hBEEFF00D, 1, 0, 0, 32'h0);
        tbl[12] = mk(0, SZ_W,  32'h11,   32'h0,        0, 32'h0,        0, 1, 0, 32'h0);
        tbl[13] = mk(1, SZ_H,  32'h23,   32'h1234,     0, 32'h0,        0, 1, 0, 32'h0);
        tbl[14] = mk(0, SZ_H,  32'h21,   32'h0,        0, 32'h0,        0, 1, 0, 32'h0);
        tbl[15] = mk(0, SZ_W,  32'h20,   32'h0,        1, 32'hBEEFF00D, 1, 0, 0, 32'h0);
        tbl[16] = mk(1, SZ_B,  32'h17,   32'hFF,       0, 32'h0,        1, 0, 1, 32'hFF000000);
        tbl[17] = mk(0, SZ_H,  32'h16,   32'h0,        1, 32'hFFFFFF00, 1, 0, 0, 32'h0);
        tbl[18] = mk(0, SZ_HU, 32'h16,   32'h0,        1, 32'h0000FF00, 1, 0, 0, 32'h0);
        tbl[19] = mk(0, SZ_B,  32'h1003, 32'h0,        1, 32'hFFFFFFDE, 1, 0, 0, 32'h0);
        tbl[20] = mk(1, SZ_W,  32'h30,   32'h11223344, 0, 32'h0,        0, 0, 1, 32'h11223344);

        // Reset with a request pending: every output must read zero.
        rst_i       = 1'b0;
        mem_init    = 1'b1;
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = SZ_W;
        core_addr_i = 32'h10;
        core_wd_i   = 32'hFFFFFFFF;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst core_rd", core_rd_o, 32'h0);
        check("rst stall", 32'(core_stall_o), 32'h0);
        check("rst misalign", 32'(misalign_o), 32'h0);
        check("rst mem_req", 32'(mem_req_o), 32'h0);
        check("rst mem_we", 32'(mem_we_o), 32'h0);
        check("rst mem_addr", mem_addr_o, 32'h0);
        check("rst mem_wd", mem_wd_o, 32'h0);
        core_req_i = 1'b0;
        rst_i      = 1'b1;
        mem_init   = 1'b0;

        for (int i = 0; i < 21; i++) run_op(i, tbl[i]);

        check("rd held after stores", core_rd_o, 32'hFFFFFFDE);
        check("mem[0x10] merged", mem[4], 32'h889923BB);
        check("mem[0x20] merged", mem[8], 32'hBEEFF00D);
        check("mem[0x14] merged", mem[5], 32'hFF000000);
        check("mem[0x30] written", mem[12], 32'h11223344);

        // Request held through the completion cycle is taken only on the next IDLE cycle.
        @(negedge clk_i);
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = SZ_W; core_addr_i = 32'h10;
        #1;
        check("b2b first req", 32'(mem_req_o), 32'h1);
        @(posedge clk_i); #1;
        check("b2b completion no req", 32'(mem_req_o), 32'h0);
        check("b2b completion no stall", 32'(core_stall_o), 32'h0);
        check("b2b completion data", core_rd_o, 32'h889923BB);
        @(posedge clk_i); #1;
        check("b2b second req", 32'(mem_req_o), 32'h1);
        check("b2b second stall", 32'(core_stall_o), 32'h1);
        core_req_i = 1'b0;
        @(posedge clk_i);

        // Reset landing in RMW_WAIT must drop the pending write.
        @(negedge clk_i);
        core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = SZ_B; core_addr_i = 32'h10; core_wd_i = 32'h55;
        @(posedge clk_i); #1;
        check("rmw pending write", 32'(mem_we_o), 32'h1);
        rst_i      = 1'b0;
        core_req_i = 1'b0;
        #1;
        check("rmw reset no we", 32'(mem_we_o), 32'h0);
        check("rmw reset no req", 32'(mem_req_o), 32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        #1;
        check("post rst stall", 32'(core_stall_o), 32'h0);
        check("post rst core_rd", core_rd_o, 32'h0);
        check("post rst mem_req", 32'(mem_req_o), 32'h0);
        check("rmw abandoned mem", mem[4], 32'h889923BB);
        run_op(100, mk(0, SZ_W, 32'h10, 32'h0, 1, 32'h889923BB, 1, 0, 0, 32'h0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
